// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the clock-enable divider bank.
// Optional phase alignment is enabled with CLK_DIV_PHASE_ALIGN_EN.
package clk_div_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int MIN_DIV   = 1;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic                 cascade;
  } chan_cfg_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed ratio/cascade config.
// Optional phase alignment is enabled with CLK_DIV_PHASE_ALIGN_EN.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prev_tick,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_cas,
  output logic             tick,
  output logic             dclk,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] sh_div;
  logic             cas_q;
  logic             sh_cas;
  logic             imm;
  logic             src;
  logic             last;
  logic             sync_hit;

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // source select and terminal-count detect
  always_comb begin
    src  = cas_q ? prev_tick : 1'b1;
    last = (cnt == div_q - CNT_W'(1));
  end

  // counter, tick, square wave and shadow config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      cas_q  <= 1'b0;
      sh_div <= '0;
      sh_cas <= 1'b0;
      pend   <= 1'b0;
      imm    <= 1'b0;
      tick   <= 1'b0;
      dclk   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync_hit) begin
        cnt  <= '0;
        dclk <= 1'b0;
        imm  <= 1'b0;
        if (pend) begin
          div_q <= sh_div;
          cas_q <= sh_cas;
          pend  <= 1'b0;
        end
      end else if (pend && imm) begin
        div_q <= sh_div;
        cas_q <= sh_cas;
        cnt   <= '0;
        pend  <= 1'b0;
        imm   <= 1'b0;
      end else if (en && src) begin
        if (last) begin
          cnt  <= '0;
          tick <= 1'b1;
          dclk <= ~dclk;
          if (pend) begin
            div_q <= sh_div;
            cas_q <= sh_cas;
            pend  <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (wr) begin
        sh_div <= wr_div;
        sh_cas <= wr_cas;
        pend   <= 1'b1;
        imm    <= ~en;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of programmable clock-enable dividers with cascade.
// Optional sync_req phase alignment is enabled with CLK_DIV_PHASE_ALIGN_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 3,
  parameter int  CNT_W       = DEF_CNT_W,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic              sync_req,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_cascade,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] hit;
  logic [CNT_W-1:0]  div_sat;
  logic              accept;

  // one-hot channel select; out-of-range channels match nothing
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = (cfg_chan == CH_W'(k));
    end
  end

  // handshake; unknown channels are always ready and writes vanish
  always_comb begin
    cfg_ready = ~|(hit & pend);
    accept    = cfg_valid && cfg_ready;
    div_sat   = (cfg_div == '0) ? CNT_W'(MIN_DIV) : cfg_div;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic prev;
    if (k == 0) begin : g_head
      assign prev = 1'b1;
    end else begin : g_link
      assign prev = div_tick[k-1];
    end

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (in_clk),
      .rst_n     (rst_n),
      .en        (en),
      .prev_tick (prev),
`ifdef CLK_DIV_PHASE_ALIGN_EN
      .sync      (sync_req),
`endif
      .wr        (accept && hit[k]),
      .wr_div    (div_sat),
      .wr_cas    (cfg_cascade),
      .tick      (div_tick[k]),
      .dclk      (div_clk[k]),
      .pend      (pend[k])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for the divider bank.
// Expected ticks are queued per run; a monitor pops them on each tick.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              in_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_cascade = 1'b0;
  logic [CH_W-1:0]   cfg_chan = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] div_tick;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] pend;
`ifdef CLK_DIV_PHASE_ALIGN_EN
  logic              sync_req = 1'b0;
`endif

  typedef struct {
    int       cyc;
    logic [2:0] tick;
    logic [2:0] clk;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   q0[$];
  int   q1[$];
  int   q2[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   f;
  int   g;

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .in_clk      (in_clk),
    .rst_n       (rst_n),
    .en          (en),
`ifdef CLK_DIV_PHASE_ALIGN_EN
    .sync_req    (sync_req),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_div     (cfg_div),
    .cfg_cascade (cfg_cascade),
    .div_tick    (div_tick),
    .div_clk     (div_clk),
    .pend        (pend)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit has(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic plan(input int base, input int last);
    logic [2:0] k;
    logic [2:0] t;
    k = '0;
    for (int c = 1; c <= last; c++) begin
      t = {has(q2, c), has(q1, c), has(q0, c)};
      if (t != '0) begin
        k = k ^ t;
        sb.push_back('{cyc: base + c, tick: t, clk: k});
      end
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge in_clk);
  endtask

  task automatic cfg_wr(input int ch, input int d, input bit cas);
    chan_cfg_t c;
    c.div       = CNT_W'(d);
    c.cascade   = cas;
    cfg_chan    = CH_W'(ch);
    cfg_div     = c.div;
    cfg_cascade = c.cascade;
    cfg_valid   = 1'b1;
    @(negedge in_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    en = 1'b0;
    @(negedge in_clk);
    rst_n = 1'b1;
    @(negedge in_clk);
  endtask

  // monitor: every tick must match the head of the scoreboard
  always @(negedge in_clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_tick cyc=%0d got=none want=%b",
               sb[0].cyc, sb[0].tick);
      void'(sb.pop_front());
    end
    if (div_tick != '0) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        total++;
        bad++;
        $display("FAIL stray_tick cyc=%0d got=%b want=none", cyc, div_tick);
      end else begin
        m = sb.pop_front();
        check("tick_vec", 32'(div_tick), 32'(m.tick));
        check("div_clk", 32'(div_clk), 32'(m.clk));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge in_clk);
    check("rst_tick", 32'(div_tick), 0);
    check("rst_clk", 32'(div_clk), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;
    @(negedge in_clk);
    check("rel_clk", 32'(div_clk), 0);

    // default ratio 2 on all channels
    f = cyc;
    q0 = '{2, 4, 6, 8};
    q1 = '{2, 4, 6, 8};
    q2 = '{2, 4, 6, 8};
    plan(f, 8);
    en = 1'b1;
    tick_to(f + 8);
    en = 1'b0;

    // cascade chain: ch0 /4, ch1 /3 of ch0, ch2 /2 of ch1
    hard_reset();
    cfg_wr(0, 4, 1'b0);
    cfg_wr(1, 3, 1'b1);
    cfg_wr(2, 2, 1'b1);
    @(negedge in_clk);
    check("pend_idle", 32'(pend), 0);
    f = cyc;
    for (int c = 4; c <= 50; c += 4) q0.push_back(c);
    q1 = '{13, 25, 37, 49};
    q2 = '{26, 50};
    plan(f, 50);
    en = 1'b1;
    tick_to(f + 50);
    en = 1'b0;

    // runtime change ch0 -> 5, busy check, write on ch1 terminal count
    hard_reset();
    f = cyc;
    q0 = '{2, 4, 9, 14, 19};
    q1 = '{2, 4, 6, 9, 12, 15, 18};
    for (int c = 2; c <= 20; c += 2) q2.push_back(c);
    plan(f, 20);
    en = 1'b1;
    tick_to(f + 2);
    cfg_chan    = 2'd0;
    cfg_div     = 16'd5;
    cfg_cascade = 1'b0;
    cfg_valid   = 1'b1;
    @(negedge in_clk);
    check("pend_staged", 32'(pend), 32'b001);
    cfg_div = 16'd7;
    #1 check("ready_busy", 32'(cfg_ready), 0);
    cfg_chan = 2'd1;
    cfg_div  = 16'd3;
    #1 check("ready_free", 32'(cfg_ready), 1);
    @(negedge in_clk);
    cfg_valid = 1'b0;
    check("pend_swap", 32'(pend), 32'b010);
    cfg_chan = 2'd0;
    #1 check("ready_back", 32'(cfg_ready), 1);
    tick_to(f + 6);
    check("pend_done", 32'(pend), 0);
    tick_to(f + 20);
    en = 1'b0;

    // zero ratio saturates to 1; out-of-range channel is dropped
    hard_reset();
    cfg_wr(2, 0, 1'b0);
    check("pend_imm", 32'(pend), 32'b100);
    cfg_chan    = 2'd3;
    cfg_div     = 16'd9;
    cfg_cascade = 1'b1;
    cfg_valid   = 1'b1;
    #1 check("ready_oob", 32'(cfg_ready), 1);
    @(negedge in_clk);
    cfg_valid = 1'b0;
    check("pend_oob", 32'(pend), 0);
    f = cyc;
    q0 = '{2, 4, 6, 8};
    q1 = '{2, 4, 6, 8};
    for (int c = 1; c <= 8; c++) q2.push_back(c);
    plan(f, 8);
    en = 1'b1;
    tick_to(f + 8);
    en = 1'b0;

    // en pause holds state, then async reset drops a pending update
    hard_reset();
    f = cyc;
    q0 = '{2, 11, 13};
    q1 = '{2, 11, 13};
    q2 = '{2, 11, 13};
    plan(f, 13);
    en = 1'b1;
    tick_to(f + 3);
    en = 1'b0;
    repeat (7) begin
      @(negedge in_clk);
      check("hold_tick", 32'(div_tick), 0);
      check("hold_clk", 32'(div_clk), 32'b111);
    end
    en = 1'b1;
    tick_to(f + 12);
    cfg_chan    = 2'd0;
    cfg_div     = 16'd5;
    cfg_cascade = 1'b0;
    cfg_valid   = 1'b1;
    @(negedge in_clk);
    cfg_valid = 1'b0;
    check("pend_at_tc", 32'(pend), 32'b001);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("async_tick", 32'(div_tick), 0);
    check("async_clk", 32'(div_clk), 0);
    check("async_pend", 32'(pend), 0);
    check("async_ready", 32'(cfg_ready), 1);
    @(negedge in_clk);
    rst_n = 1'b1;
    @(negedge in_clk);
    g = cyc;
    q0 = '{2, 4};
    q1 = '{2, 4};
    q2 = '{2, 4};
    plan(g, 4);
    en = 1'b1;
    tick_to(g + 4);
    en = 1'b0;

`ifdef CLK_DIV_PHASE_ALIGN_EN
    // offset phases at /3, then sync_req realigns all channels
    hard_reset();
    cfg_wr(0, 3, 1'b0);
    cfg_wr(1, 3, 1'b0);
    cfg_wr(2, 3, 1'b0);
    @(negedge in_clk);
    f = cyc;
    q0 = '{3, 8};
    q1 = '{3, 9};
    q2 = '{3, 8};
    plan(f, 9);
    en = 1'b1;
    tick_to(f + 4);
    en = 1'b0;
    cfg_wr(1, 3, 1'b0);
    @(negedge in_clk);
    en = 1'b1;
    tick_to(f + 9);
    sync_req = 1'b1;
    @(negedge in_clk);
    sync_req = 1'b0;
    check("sync_clk", 32'(div_clk), 0);
    q0 = '{13};
    q1 = '{13};
    q2 = '{13};
    plan(f, 13);
    tick_to(f + 13);
    en = 1'b0;
`endif

    repeat (4) @(negedge in_clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
